// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if
// Purpose: groups the pattern/enable inputs and the LED drive/busy outputs of
//          led_fade_pwm into one bundle.
// Signals:
//   led_in  [N_LED] target on/off pattern from the shifter (1 = channel on)
//   enable          1 = fading/PWM active, 0 = all LEDs dark and state cleared
//   led_out [N_LED] registered PWM drive to the LED pins, active-high
//   busy            1 = at least one channel is still fading toward its target
// Modports: master = pattern source side, slave = led_fade_pwm side.
interface led_fade_pwm_if #(
  parameter int N_LED = 5
) ();
  logic [N_LED-1:0] led_in;
  logic             enable;
  logic [N_LED-1:0] led_out;
  logic             busy;

  modport master (
    output led_in,
    output enable,
    input  led_out,
    input  busy
  );

  modport slave (
    input  led_in,
    input  enable,
    output led_out,
    output busy
  );
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
// Purpose: PWM LED driver that ramps each channel's duty toward its on/off
//          target once per PWM period, turning a hard-stepping LED pattern into
//          a smooth fading comet.
// Ports:
//   sys_clk    system clock (50 MHz)
//   sys_rst_n  synchronous active-low reset
//   bus        led_fade_pwm_if.slave: led_in, enable (in); led_out, busy (out)
// Optional build macro: LED_FADE_GAMMA_EN
//   defined   -> compare value is (duty*duty) >> PWM_BITS (square-law brightness)
//   undefined -> compare value is duty (linear, no multiplier)
module led_fade_pwm #(
  parameter int N_LED     = 5,
  parameter int PWM_BITS  = 8,
  parameter int PWM_DIV   = 195,
  parameter int FADE_STEP = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  led_fade_pwm_if.slave bus
);

  // Prescaler width; PWM_DIV=1 still needs a one-bit counter that stays at 0.
  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PWM_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS:0]   MAX_X    = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS + 1)'(FADE_STEP);

  logic [DIV_W-1:0]                r_div_cnt;
  logic [PWM_BITS-1:0]             r_pwm_cnt;
  logic [N_LED-1:0][PWM_BITS-1:0]  r_duty;
  logic [N_LED-1:0]                r_led_in_q;
  logic [N_LED-1:0]                r_led_out;
  logic                            r_busy;

  logic                            w_tick;
  logic                            w_period_end;
  logic [N_LED-1:0][PWM_BITS-1:0]  w_duty_next;
  logic [N_LED-1:0][PWM_BITS-1:0]  w_cmp;
  logic [N_LED-1:0][PWM_BITS-1:0]  w_target;
  logic [N_LED-1:0]                w_led_next;
  logic                            w_busy_next;
  logic [PWM_BITS:0]               w_up;
  logic [PWM_BITS:0]               w_dn;

  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_period_end = w_tick && (r_pwm_cnt == MAX);

  always_comb begin
    w_duty_next = r_duty;
    w_cmp       = r_duty;
    w_target    = '0;
    w_led_next  = '0;
    w_busy_next = 1'b0;
    w_up        = '0;
    w_dn        = '0;
    for (int i = 0; i < N_LED; i++) begin
      w_target[i] = r_led_in_q[i] ? MAX : '0;
      // One extra bit: overflow shows as > MAX, underflow as a set MSB.
      w_up = {1'b0, r_duty[i]} + STEP_X;
      w_dn = {1'b0, r_duty[i]} - STEP_X;
      if (r_duty[i] < w_target[i]) begin
        w_duty_next[i] = (w_up > MAX_X) ? MAX : w_up[PWM_BITS-1:0];
      end else if (r_duty[i] > w_target[i]) begin
        w_duty_next[i] = w_dn[PWM_BITS] ? '0 : w_dn[PWM_BITS-1:0];
      end
      if (w_duty_next[i] != w_target[i]) begin
        w_busy_next = 1'b1;
      end
`ifdef LED_FADE_GAMMA_EN
      w_cmp[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, r_duty[i]} *
                            {{PWM_BITS{1'b0}}, r_duty[i]}) >> PWM_BITS);
`else
      w_cmp[i] = r_duty[i];
`endif
      // Full duty is forced solid on; the compare alone would leave one low count.
      w_led_next[i] = (r_duty[i] == MAX) || (r_pwm_cnt < w_cmp[i]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_div_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_duty     <= '0;
      r_led_in_q <= '0;
      r_led_out  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_led_in_q <= bus.led_in;
      if (!bus.enable) begin
        r_div_cnt <= '0;
        r_pwm_cnt <= '0;
        r_duty    <= '0;
        r_led_out <= '0;
        r_busy    <= 1'b0;
      end else begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        if (w_tick) begin
          r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
        // Duty only moves at the period boundary so no runt pulses appear.
        if (w_period_end) begin
          r_duty <= w_duty_next;
          r_busy <= w_busy_next;
        end
        r_led_out <= w_led_next;
      end
    end
  end

  assign bus.led_out = r_led_out;
  assign bus.busy    = r_busy;

endmodule
